seq_priority_encoder: RTL and testbench

SEQ_PRIORITY_ENCODER -- requirements
Module: seq_priority_encoder

---
 rtl/seq_enc_pkg.sv | 5 +
 rtl/prio_find.sv | 22 ++
 rtl/seq_priority_encoder.sv | 68 ++++++
 tb/tb_seq_priority_encoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seq_enc_pkg.sv
// seq_enc_pkg: shared state encoding and default width for the sequential priority encoder
package seq_enc_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/prio_find.sv
// prio_find: direction-selectable find-first-set with at-most-one-bit detection
module prio_find #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             single
);
    assign found  = |vec;
    assign single = (vec & (vec - WIDTH'(1))) == '0;
    // later loop iterations override earlier ones, so each loop scans toward its winning end
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (!msb_first && vec[i]) idx = IDX_W'(i);
        for (int i = 0; i < WIDTH; i++)
            if (msb_first && vec[i]) idx = IDX_W'(i);
    end
endmodule

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: captures a request vector and emits its set-bit indices one beat at a time in priority order
module seq_priority_encoder
    import seq_enc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             msb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] pending, pending_nx;
    logic             mode, mode_nx;
    logic [IDX_W-1:0] f_idx;
    logic             found, single;

    prio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find (
        .vec      (pending),
        .msb_first(mode),
        .idx      (f_idx),
        .found    (found),
        .single   (single)
    );

    assign out_valid = state == DRAIN;
    assign out_idx   = out_valid ? f_idx : '0;
    assign out_last  = out_valid & single;
    assign out_zero  = out_valid & ~found;
    assign in_ready  = (state == IDLE) | (out_valid & out_last & out_ready);

    // consume the current beat, then let a new capture take precedence over returning to idle
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        mode_nx    = mode;
        if (out_valid && out_ready) begin
            pending_nx = pending & ~(WIDTH'(1) << f_idx);
            state_nx   = out_last ? IDLE : DRAIN;
        end
        if (in_valid && in_ready) begin
            pending_nx = in_vec;
            mode_nx    = msb_first;
            state_nx   = DRAIN;
        end
    end

    // state, pending vector and direction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            mode    <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            mode    <= mode_nx;
        end
    end
endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb_seq_priority_encoder: table-driven and directed checks of the sequential priority encoder
module tb_seq_priority_encoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, msb_first, out_valid, out_ready, out_last, out_zero;
    logic [7:0] in_vec;
    logic [2:0] out_idx;

    logic       b_in_valid, b_in_ready, b_msb_first, b_out_valid, b_out_ready, b_out_last, b_out_zero;
    logic [4:0] b_in_vec;
    logic [2:0] b_out_idx;

    seq_priority_encoder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .msb_first(msb_first), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .out_zero(out_zero)
    );

    seq_priority_encoder #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
        .msb_first(b_msb_first), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_idx(b_out_idx), .out_last(b_out_last), .out_zero(b_out_zero)
    );

    typedef struct {
        logic [7:0]  vec;
        logic        msb;
        int          n;
        logic [31:0] ix;
        logic        zero;
    } vec_t;

    vec_t tbl[8];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0] = '{8'b1001_0010, 1'b0, 3, 32'h741,      1'b0};
        tbl[1] = '{8'b1001_0010, 1'b1, 3, 32'h147,      1'b0};
        tbl[2] = '{8'b0000_0000, 1'b0, 1, 32'h0,        1'b1};
        tbl[3] = '{8'b1111_1111, 1'b0, 8, 32'h76543210, 1'b0};
        tbl[4] = '{8'b1000_0000, 1'b1, 1, 32'h7,        1'b0};
        tbl[5] = '{8'b0101_0101, 1'b1, 4, 32'h0246,     1'b0};
        tbl[6] = '{8'b0000_0001, 1'b0, 1, 32'h0,        1'b0};
        tbl[7] = '{8'b1100_0011, 1'b0, 4, 32'h7610,     1'b0};

        rst = 1'b1;
        in_valid = 1'b1; in_vec = 8'hff; msb_first = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_vec = '0; b_msb_first = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1; in_vec = tbl[t].vec; msb_first = tbl[t].msb; out_ready = 1'b1;
            chk($sformatf("v%0d_idle_in_ready", t), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0; in_vec = ~tbl[t].vec; msb_first = ~tbl[t].msb;
            for (int b = 0; b < tbl[t].n; b++) begin
                chk($sformatf("v%0d_b%0d_valid", t, b), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d_b%0d_idx", t, b),   32'(out_idx),   32'(tbl[t].ix[4*b +: 3]));
                chk($sformatf("v%0d_b%0d_last", t, b),  32'(out_last),  32'(b == tbl[t].n - 1));
                chk($sformatf("v%0d_b%0d_zero", t, b),  32'(out_zero),  32'(tbl[t].zero));
                chk($sformatf("v%0d_b%0d_in_ready", t, b), 32'(in_ready), 32'(b == tbl[t].n - 1));
                @(negedge clk);
            end
            chk($sformatf("v%0d_done", t), 32'(out_valid), 32'd0);
        end

        in_valid = 1'b1; in_vec = 8'b0000_1100; msb_first = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_idx", i),   32'(out_idx),   32'd2);
            chk($sformatf("stall%0d_last", i),  32'(out_last),  32'd0);
            chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("stall_go_idx",  32'(out_idx),  32'd2);
        @(negedge clk);
        chk("stall_b1_idx",  32'(out_idx),  32'd3);
        chk("stall_b1_last", 32'(out_last), 32'd1);
        @(negedge clk);
        chk("stall_done", 32'(out_valid), 32'd0);

        in_valid = 1'b1; in_vec = 8'b1000_0000; msb_first = 1'b0;
        @(negedge clk);
        in_vec = 8'b0000_0001;
        chk("b2b_a_valid",    32'(out_valid), 32'd1);
        chk("b2b_a_idx",      32'(out_idx),   32'd7);
        chk("b2b_a_last",     32'(out_last),  32'd1);
        chk("b2b_a_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_b_valid", 32'(out_valid), 32'd1);
        chk("b2b_b_idx",   32'(out_idx),   32'd0);
        chk("b2b_b_last",  32'(out_last),  32'd1);
        @(negedge clk);
        chk("b2b_done", 32'(out_valid), 32'd0);

        b_in_valid = 1'b1; b_in_vec = 5'b11111; b_msb_first = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("w5_b%0d_valid", b), 32'(b_out_valid), 32'd1);
            chk($sformatf("w5_b%0d_idx", b),   32'(b_out_idx),   32'(4 - b));
            chk($sformatf("w5_b%0d_last", b),  32'(b_out_last),  32'(b == 4));
            @(negedge clk);
        end
        chk("w5_done", 32'(b_out_valid), 32'd0);

        b_in_valid = 1'b1; b_in_vec = 5'b11111; b_msb_first = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("w5r_b0_idx", 32'(b_out_idx), 32'd0);
        @(negedge clk);
        chk("w5r_b1_idx", 32'(b_out_idx), 32'd1);
        @(negedge clk);
        chk("w5r_b2_idx", 32'(b_out_idx), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("w5r_async_valid",    32'(b_out_valid), 32'd0);
        chk("w5r_async_in_ready", 32'(b_in_ready),  32'd1);
        chk("w5r_async_idx",      32'(b_out_idx),   32'd0);
        chk("w5r_async_last",     32'(b_out_last),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("w5r_after%0d_valid", i), 32'(b_out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
